pwm_multichannel_ctrl: RTL and testbench
========================================

Name: pwm_multichannel_ctrl

Overview:
Next-generation PWM generator with CHANNELS independent outputs sharing one period counter.
- Per-channel duty adjusted by two push-button inputs, internally debounced and edge-detected, routed to the channel selected by `ch_sel`.
- Period is runtime-programmable. Duty and period changes are double-buffered and only take effect at a period boundary, so output is glitch-free.
- Sits behind the top-level pin wrapper: buttons and selects come from dedicated inputs, `pwm_out` drives dedicated outputs.

Parameters:
- CHANNELS, 4: number of PWM outputs (1..8).
- WIDTH, 8: period counter width in bits.
- DEB_DIV, 250000: clocks per debounce sample tick (set to 2 in simulation).
- STEP, 1: duty change per accepted button event, in counts.
- RESET_DUTY, 5: duty loaded into every channel at reset.
- RESET_PERIOD, 9: period loaded at reset (10 counts per cycle).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  block enable.
- btn_inc  in  1  raw increase-duty button, asynchronous and bouncing.
- btn_dec  in  1  raw decrease-duty button.
- ch_sel  in  CW  target channel for button events; CW = max(1, clog2(CHANNELS)).
- period_in  in  WIDTH  requested terminal count (cycle = period_in+1 clocks).
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_end  out  1  one-cycle pulse in the clock the counter wraps.
- duty_rd  out  WIDTH+1  pending duty of the channel selected by `ch_sel` (combinational mux of registers).

Behaviour:
- Reset: one clock, synchronous, active-low, fixed. While rst_n=0 at a rising edge:
  - cnt=0, period_act=RESET_PERIOD.
  - All duty_pend and duty_act = RESET_DUTY.
  - pwm_out=0, period_end=0, debounce state and prescaler cleared.
  - Reset mid-cycle takes effect on that edge; no partial-cycle state is retained.
- ena=0:
  - cnt, prescaler and debouncers hold.
  - pwm_out is forced to 0 on the next edge; period_end=0.
  - Resuming continues from the held count.
- Counter: cnt (WIDTH bits) increments each enabled clock. When cnt==period_act, cnt goes to 0 and period_end=1 for that cycle.
- Shadow load: on the wrap edge, period_act<=period_in and each duty_act<=min(duty_pend, period_in+1). A period_in change mid-cycle never shortens or extends the current cycle.
- Output: pwm_out[i] <= (cnt < duty_act[i]), i.e. one clock latency from cnt.
  - duty_act=0 gives constant low.
  - duty_act >= period_act+1 gives constant high (100%).
- Duty width: WIDTH+1 bits, so 100% duty is representable at max period.
- Debounce, per button:
  - Prescaler tick fires every DEB_DIV enabled clocks.
  - On tick, s1<=btn and s2<=s1.
  - Event pulse = s1 & ~s2 & tick: one clock, at most once per press.
- Duty update, the clock after an event, on channel ch_sel:
  - inc only: duty_pend <= min(duty_pend+STEP, period_act+1).
  - dec only: duty_pend <= max(duty_pend-STEP, 0), with no underflow wrap.
  - Simultaneous inc and dec events in the same clock are both discarded.
  - ch_sel >= CHANNELS: event discarded.
  - New duty reaches pwm_out only after the next wrap (shadow load) plus one clock.
- Held button: exactly one event per press; release then re-press is needed for another.

Test Plan:
- Reset values: rst_n=0 for 3 clocks then 1, period_in=9, ena=1 -> pwm_out all 0 in the first cycle after reset, then each channel high 5 of every 10 clocks; period_end pulses every 10 clocks.
- Increase: DEB_DIV=2, ch_sel=2, btn_inc held 8 clocks -> exactly one event; duty_rd 5→6; pwm_out[2] high 6/10 starting the cycle after the next period_end; other channels remain 5/10.
- Saturation and floor: 6 inc presses on channel 0 -> duty_rd saturates at 10, pwm_out[0] constantly high; then 11 dec presses -> duty_rd 0, pwm_out[0] constantly low, no wrap to a large value.
- Simultaneous events: btn_inc and btn_dec rise together -> duty_rd unchanged on all channels.
- Period change mid-cycle: at cnt=4 set period_in=19 with duty 5 -> current cycle still 10 clocks; following cycles 20 clocks, high 5.
- Period clamp: duty_pend=10, then period_in changed 9→3 -> after wrap duty_act=4, output constantly high; ena=0 mid-cycle -> pwm_out 0 next edge, cnt frozen, resumes from the same value when ena=1; rst_n=0 mid-cycle -> all duties return to 5 on that edge.

Source files
------------

// File: rtl/pwm_multichannel_ctrl.sv
// rtl/pwm_multichannel_ctrl.sv - multichannel PWM with shared period counter,
// button-driven duty adjustment and period-boundary shadow loading.
module pwm_multichannel_ctrl #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 8,
  parameter int DEB_DIV      = 250000,
  parameter int STEP         = 1,
  parameter int RESET_DUTY   = 5,
  parameter int RESET_PERIOD = 9,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                btn_inc,
  input  logic                btn_dec,
  input  logic [CW-1:0]       ch_sel,
  input  logic [WIDTH-1:0]    period_in,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_end,
  output logic [WIDTH:0]      duty_rd
);

  localparam int PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam int DW = WIDTH + 1;
  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    period_act_q, period_act_d;
  logic [DW-1:0]       duty_pend_q [CHANNELS];
  logic [DW-1:0]       duty_pend_d [CHANNELS];
  logic [DW-1:0]       duty_act_q  [CHANNELS];
  logic [DW-1:0]       duty_act_d  [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_end_q, period_end_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [1:0]          s1_q, s1_d, s2_q, s2_d;

  logic          tick, wrap, sel_ok, inc_ev, dec_ev;
  logic [DW-1:0] sel_pend, new_duty, load_lim;
  logic [EW-1:0] inc_sum, inc_lim;

  always_comb begin
    tick     = ena && (pre_q == PW'(DEB_DIV - 1));
    wrap     = (cnt_q == period_act_q);
    sel_ok   = (32'(ch_sel) < CHANNELS);
    sel_pend = sel_ok ? duty_pend_q[ch_sel] : '0;
    inc_ev   = tick && s1_q[0] && !s2_q[0];
    dec_ev   = tick && s1_q[1] && !s2_q[1];
    load_lim = {1'b0, period_in} + DW'(1);
    inc_sum  = EW'(sel_pend) + EW'(STEP);
    inc_lim  = EW'(period_act_q) + EW'(1);
    // Widened sum so saturation still works when the duty sits at full scale.
    if (inc_sum > inc_lim) new_duty = inc_lim[DW-1:0];
    else                   new_duty = inc_sum[DW-1:0];
    if (dec_ev) new_duty = (sel_pend >= DW'(STEP)) ? sel_pend - DW'(STEP) : '0;

    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    period_end_d = 1'b0;
    pre_d        = pre_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    pwm_d        = '0;
    duty_pend_d  = duty_pend_q;
    duty_act_d   = duty_act_q;

    if (ena) begin
      cnt_d        = wrap ? '0 : cnt_q + WIDTH'(1);
      period_end_d = wrap;
      pre_d        = tick ? '0 : pre_q + PW'(1);
      if (wrap) period_act_d = period_in;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = ({1'b0, cnt_q} < duty_act_q[i]);
        if (wrap)
          duty_act_d[i] = (duty_pend_q[i] > load_lim) ? load_lim : duty_pend_q[i];
      end
    end

    if (tick) begin
      s1_d = {btn_dec, btn_inc};
      s2_d = s1_q;
    end

    // Coincident inc/dec events cancel each other.
    if ((inc_ev ^ dec_ev) && sel_ok) begin
      for (int i = 0; i < CHANNELS; i++)
        if (32'(ch_sel) == i) duty_pend_d[i] = new_duty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      period_act_q <= WIDTH'(RESET_PERIOD);
      period_end_q <= 1'b0;
      pwm_q        <= '0;
      pre_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      duty_pend_q  <= '{default: DW'(RESET_DUTY)};
      duty_act_q   <= '{default: DW'(RESET_DUTY)};
    end else begin
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      period_end_q <= period_end_d;
      pwm_q        <= pwm_d;
      pre_q        <= pre_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      duty_pend_q  <= duty_pend_d;
      duty_act_q   <= duty_act_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign period_end = period_end_q;
  assign duty_rd    = sel_pend;

endmodule

// File: tb/tb_pwm_multichannel_ctrl.sv
// tb/tb_pwm_multichannel_ctrl.sv - directed self-checking bench for pwm_multichannel_ctrl.
module tb_pwm_multichannel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [1:0] ch_sel = 2'd0;
  logic [7:0] period_in = 8'd9;
  logic [3:0] pwm_out;
  logic       period_end;
  logic [8:0] duty_rd;

  int tests = 0;
  int fails = 0;
  int hi [4];
  int pe_n;
  int len;

  pwm_multichannel_ctrl #(
    .CHANNELS(4), .WIDTH(8), .DEB_DIV(2), .STEP(1), .RESET_DUTY(5), .RESET_PERIOD(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .ch_sel(ch_sel), .period_in(period_in), .pwm_out(pwm_out),
    .period_end(period_end), .duty_rd(duty_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic inc, input logic dec);
    @(negedge clk);
    btn_inc = inc;
    btn_dec = dec;
    repeat (8) @(negedge clk);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_pe();
    bit got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (period_end) got = 1;
    end
    if (!got) check("pe_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure(input int n);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    pe_n = 0;
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (pwm_out[c]) hi[c]++;
      if (period_end) pe_n++;
    end
  endtask

  task automatic check_hi(input string tag, input int e0, input int e1, input int e2,
                          input int e3, input int epe);
    check({tag, "_ch0"}, hi[0], e0);
    check({tag, "_ch1"}, hi[1], e1);
    check({tag, "_ch2"}, hi[2], e2);
    check({tag, "_ch3"}, hi[3], e3);
    check({tag, "_pe"}, pe_n, epe);
  endtask

  task automatic check_duty(input string tag, input int e0, input int e1, input int e2,
                            input int e3);
    logic [1:0] saved;
    saved = ch_sel;
    ch_sel = 2'd0; #1 check({tag, "_duty0"}, duty_rd, e0);
    ch_sel = 2'd1; #1 check({tag, "_duty1"}, duty_rd, e1);
    ch_sel = 2'd2; #1 check({tag, "_duty2"}, duty_rd, e2);
    ch_sel = 2'd3; #1 check({tag, "_duty3"}, duty_rd, e3);
    ch_sel = saved;
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    period_in = 8'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pwm", pwm_out, 4'h0);
    check("rst_pe", period_end, 1'b0);
    check_duty("rst", 5, 5, 5, 5);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_high", pwm_out, 4'hF);
    wait_pe();
    measure(10);
    check_hi("reset_cycle", 5, 5, 5, 5, 1);

    ch_sel = 2'd2;
    press(1'b1, 1'b0);
    check_duty("inc", 5, 5, 6, 5);
    wait_pe();
    measure(10);
    check_hi("inc_cycle", 5, 5, 6, 5, 1);

    ch_sel = 2'd0;
    repeat (6) press(1'b1, 1'b0);
    check_duty("sat", 10, 5, 6, 5);
    wait_pe();
    measure(10);
    check_hi("sat_cycle", 10, 5, 6, 5, 1);
    ch_sel = 2'd0;
    repeat (11) press(1'b0, 1'b1);
    check_duty("floor", 0, 5, 6, 5);
    wait_pe();
    measure(10);
    check_hi("floor_cycle", 0, 5, 6, 5, 1);

    ch_sel = 2'd1;
    press(1'b1, 1'b1);
    check_duty("simul", 0, 5, 6, 5);

    wait_pe();
    len = 0;
    do begin
      @(negedge clk);
      len++;
      if (len == 4) period_in = 8'd19;
    end while (!period_end && len < 100);
    check("midcycle_len", len, 10);
    measure(20);
    check_hi("period20", 0, 5, 6, 5, 1);

    period_in = 8'd9;
    wait_pe();
    ch_sel = 2'd0;
    repeat (10) press(1'b1, 1'b0);
    check_duty("pend10", 10, 5, 6, 5);
    period_in = 8'd3;
    wait_pe();
    measure(4);
    check_hi("clamp", 4, 4, 4, 4, 1);
    check_duty("clamp", 10, 5, 6, 5);

    wait_pe();
    @(negedge clk);
    check("pre_ena_pwm", pwm_out, 4'hF);
    ena = 1'b0;
    @(negedge clk);
    check("ena0_pwm", pwm_out, 4'h0);
    check("ena0_pe", period_end, 1'b0);
    measure(4);
    check_hi("ena0_hold", 0, 0, 0, 0, 0);
    ena = 1'b1;
    len = 0;
    do begin
      @(negedge clk);
      len++;
      if (len == 1) check("resume_pwm", pwm_out, 4'hF);
    end while (!period_end && len < 100);
    check("resume_len", len, 3);

    period_in = 8'd9;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pwm", pwm_out, 4'h0);
    check("midrst_pe", period_end, 1'b0);
    check_duty("midrst", 5, 5, 5, 5);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_first_high", pwm_out, 4'hF);
    wait_pe();
    measure(10);
    check_hi("midrst_cycle", 5, 5, 5, 5, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
